// File: rtl/hyperbus_rx_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_packer_pkg
//  Purpose  : Shared types and constants for the HyperBus read-data packer.
//             The beat struct is sized from HYPER_NB_WORDS, so a packer
//             instance must use the same NB_WORDS as this package.
//  Contents : HYPER_WORD_W, HYPER_NB_WORDS, HYPER_LEN_W, rx_state_e,
//             rx_beat_t {data, strb, last, error}, rx_cmd_t {len, offset}
//  Revision : 1.0  initial release
// ============================================================================
package hyperbus_rx_packer_pkg;

    localparam int HYPER_WORD_W   = 16;
    localparam int HYPER_NB_WORDS = 2;
    localparam int HYPER_LEN_W    = 16;
    localparam int HYPER_DW       = HYPER_WORD_W * HYPER_NB_WORDS;
    localparam int HYPER_OFF_W    = $clog2(HYPER_NB_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_FLUSH = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [HYPER_DW-1:0]         data;
        logic [2*HYPER_NB_WORDS-1:0] strb;
        logic                        last;
        logic                        error;
    } rx_beat_t;

    typedef struct packed {
        logic [HYPER_LEN_W-1:0] len;
        logic [HYPER_OFF_W-1:0] offset;
    } rx_cmd_t;

endpackage
`default_nettype wire

// File: rtl/hyperbus_rx_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_packer_if
//  Purpose  : Bundles the command, CDC-FIFO pop and read-beat channels of the
//             packer.
//  Modports : master - the packer (drives cmd_ready, fifo_ready, rx_*, drop)
//             slave  - the surrounding controller / FIFO / AXI side
//  Revision : 1.0  initial release
// ============================================================================
interface hyperbus_rx_packer_if
    import hyperbus_rx_packer_pkg::*;
#(
    parameter int NB_WORDS = HYPER_NB_WORDS,
    parameter int LEN_W    = HYPER_LEN_W
);
    localparam int DW    = HYPER_WORD_W * NB_WORDS;
    localparam int OFF_W = $clog2(NB_WORDS);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_len;
    logic [OFF_W-1:0]        cmd_offset;
    logic                    fifo_valid;
    logic [HYPER_WORD_W-1:0] fifo_data;
    logic                    fifo_ready;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [DW-1:0]           rx_data;
    logic [2*NB_WORDS-1:0]   rx_strb;
    logic                    rx_last;
    logic                    rx_error;
    logic                    drop;

    modport master (
        input  cmd_valid, cmd_len, cmd_offset, fifo_valid, fifo_data, rx_ready,
        output cmd_ready, fifo_ready, rx_valid, rx_data, rx_strb, rx_last,
               rx_error, drop
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_offset, fifo_valid, fifo_data, rx_ready,
        input  cmd_ready, fifo_ready, rx_valid, rx_data, rx_strb, rx_last,
               rx_error, drop
    );

endinterface
`default_nettype wire

// File: rtl/hyperbus_rx_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_beat_reg
//  Purpose  : Single-entry valid/ready register for one packed read beat.
//             Contents stay stable while out_valid && !out_ready; a new beat
//             may be loaded in the same cycle the held one is taken.
//  Ports    : clk0, rst_i (async, active-high)
//             in_valid/in_ready/in_beat    - load side
//             out_valid/out_ready/out_beat - read-channel side
//  Revision : 1.0  initial release
// ============================================================================
module hyperbus_rx_beat_reg
    import hyperbus_rx_packer_pkg::*;
(
    input  wire logic     clk0,
    input  wire logic     rst_i,
    input  wire logic     in_valid,
    output logic          in_ready,
    input  wire rx_beat_t in_beat,
    output logic          out_valid,
    input  wire logic     out_ready,
    output rx_beat_t      out_beat
);

    logic     r_valid;
    rx_beat_t r_beat;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_beat  = r_beat;

    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (in_valid && in_ready) begin
            r_valid <= 1'b1;
            r_beat  <= in_beat;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hyperbus_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_rx_packer
//  Purpose  : Packs 16-bit words popped from the RWDS read CDC FIFO into
//             NB_WORDS-wide beats per read command, starting at a lane
//             offset, with byte strobes, last flag, RWDS-stall timeout and
//             discard of stray words while idle.
//  Ports    : clk0, rst_i (async, active-high)
//             bus (hyperbus_rx_packer_if.master): cmd_*, fifo_*, rx_*, drop
//  Params   : NB_WORDS (must equal HYPER_NB_WORDS), LEN_W, TIMEOUT_CYCLES
//  Revision : 1.0  initial release
// ============================================================================
module hyperbus_rx_packer
    import hyperbus_rx_packer_pkg::*;
#(
    parameter int NB_WORDS       = HYPER_NB_WORDS,
    parameter int LEN_W          = HYPER_LEN_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input wire logic            clk0,
    input wire logic            rst_i,
    hyperbus_rx_packer_if.master bus
);

    localparam int DW    = HYPER_WORD_W * NB_WORDS;
    localparam int OFF_W = $clog2(NB_WORDS);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OFF_W-1:0] LAST_LANE   = OFF_W'(NB_WORDS - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_VAL = TO_W'(TIMEOUT_CYCLES);
    localparam logic [LEN_W-1:0] ONE_WORD    = LEN_W'(1);

    rx_state_e             r_state,     w_state_nxt;
    logic [LEN_W-1:0]      r_remaining, w_remaining_nxt;
    logic [OFF_W-1:0]      r_lane,      w_lane_nxt;
    logic [DW-1:0]         r_asm_data,  w_asm_data_nxt;
    logic [2*NB_WORDS-1:0] r_asm_strb,  w_asm_strb_nxt;
    logic [TO_W-1:0]       r_timer,     w_timer_nxt;

    logic [DW-1:0]         w_fill_data;
    logic [2*NB_WORDS-1:0] w_fill_strb;
    rx_cmd_t               w_cmd;
    rx_beat_t              w_beat_in;
    rx_beat_t              w_beat_out;
    logic                  w_push;
    logic                  w_slot_free;
    logic                  w_out_valid;
    logic                  w_cmd_ready;
    logic                  w_fifo_ready;
    logic                  w_drop;

    assign w_cmd.len    = bus.cmd_len;
    assign w_cmd.offset = bus.cmd_offset;

    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RX_IDLE;
            r_remaining <= '0;
            r_lane      <= '0;
            r_asm_data  <= '0;
            r_asm_strb  <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_lane      <= w_lane_nxt;
            r_asm_data  <= w_asm_data_nxt;
            r_asm_strb  <= w_asm_strb_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_lane_nxt      = r_lane;
        w_asm_data_nxt  = r_asm_data;
        w_asm_strb_nxt  = r_asm_strb;
        w_timer_nxt     = r_timer;
        w_cmd_ready     = 1'b0;
        w_fifo_ready    = 1'b0;
        w_drop          = 1'b0;
        w_push          = 1'b0;
        w_beat_in       = '0;

        // Assembly buffer as it would look with the incoming word in place.
        w_fill_data = r_asm_data;
        w_fill_strb = r_asm_strb;
        w_fill_data[int'(r_lane)*HYPER_WORD_W +: HYPER_WORD_W] = bus.fifo_data;
        w_fill_strb[int'(r_lane)*2 +: 2] = 2'b11;

        case (r_state)
            RX_IDLE: begin
                w_cmd_ready  = 1'b1;
                w_fifo_ready = 1'b1;
                // Anything popped here has no command to belong to.
                w_drop       = bus.fifo_valid;
                if (bus.cmd_valid) begin
                    w_remaining_nxt = (w_cmd.len == '0) ? ONE_WORD : w_cmd.len;
                    w_lane_nxt      = w_cmd.offset;
                    w_asm_data_nxt  = '0;
                    w_asm_strb_nxt  = '0;
                    w_timer_nxt     = '0;
                    w_state_nxt     = RX_RECV;
                end
            end

            RX_RECV: begin
                // Only pop when a completed beat is guaranteed a home.
                w_fifo_ready = w_slot_free;
                if (bus.fifo_valid && w_slot_free) begin
                    w_remaining_nxt = r_remaining - ONE_WORD;
                    w_lane_nxt      = r_lane + OFF_W'(1);
                    w_timer_nxt     = '0;
                    w_asm_data_nxt  = w_fill_data;
                    w_asm_strb_nxt  = w_fill_strb;
                    if ((r_lane == LAST_LANE) || (r_remaining == ONE_WORD)) begin
                        w_push          = 1'b1;
                        w_beat_in.data  = w_fill_data;
                        w_beat_in.strb  = w_fill_strb;
                        w_beat_in.last  = (r_remaining == ONE_WORD);
                        w_asm_data_nxt  = '0;
                        w_asm_strb_nxt  = '0;
                        if (r_remaining == ONE_WORD) begin
                            w_state_nxt = RX_IDLE;
                        end
                    end
                end else begin
                    // Backpressure cycles count too: a stuck AXI side must
                    // not hold the controller forever.
                    w_timer_nxt = r_timer + TO_W'(1);
                    if (w_timer_nxt == TIMEOUT_VAL) begin
                        w_state_nxt = RX_FLUSH;
                    end
                end
            end

            RX_FLUSH: begin
                // Emit whatever was gathered, even an empty beat, so the
                // read channel always sees a terminating last.
                if (w_slot_free) begin
                    w_push          = 1'b1;
                    w_beat_in.data  = r_asm_data;
                    w_beat_in.strb  = r_asm_strb;
                    w_beat_in.last  = 1'b1;
                    w_beat_in.error = 1'b1;
                    w_asm_data_nxt  = '0;
                    w_asm_strb_nxt  = '0;
                    w_state_nxt     = RX_IDLE;
                end
            end

            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    hyperbus_rx_beat_reg u_beat_reg (
        .clk0      (clk0),
        .rst_i     (rst_i),
        .in_valid  (w_push),
        .in_ready  (w_slot_free),
        .in_beat   (w_beat_in),
        .out_valid (w_out_valid),
        .out_ready (bus.rx_ready),
        .out_beat  (w_beat_out)
    );

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.fifo_ready = w_fifo_ready;
    assign bus.drop       = w_drop;
    assign bus.rx_valid   = w_out_valid;
    assign bus.rx_data    = w_beat_out.data;
    assign bus.rx_strb    = w_beat_out.strb;
    assign bus.rx_last    = w_beat_out.last;
    assign bus.rx_error   = w_beat_out.error;

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyperbus_rx_packer
//  Purpose  : Self-checking bench for hyperbus_rx_packer (NB_WORDS=2,
//             TIMEOUT_CYCLES=8). Expected beats come from word positions
//             (offset + index) divided into beats and lanes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hyperbus_rx_packer;
    import hyperbus_rx_packer_pkg::*;

    localparam int NB = 2;
    localparam int TO = 8;

    logic clk0  = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk0 = ~clk0;

    hyperbus_rx_packer_if #(.NB_WORDS(NB), .LEN_W(16)) bus ();

    hyperbus_rx_packer #(
        .NB_WORDS       (NB),
        .LEN_W          (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk0  (clk0),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          drops    = 0;
    int          pops     = 0;
    int          n_exp    = 0;
    int          ready_pct = 100;
    int          gap_pct   = 0;
    bit          cmd_acc  = 1'b0;
    bit          hold_pending = 1'b0;
    rx_beat_t    held;
    rx_beat_t    got_q[$];
    int          got_cyc_q[$];
    int          pop_cyc_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] words_q[$];
    rx_beat_t    exp_a[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rx_beat_t cur_beat();
        rx_beat_t b;
        b.data  = bus.rx_data;
        b.strb  = bus.rx_strb;
        b.last  = bus.rx_last;
        b.error = bus.rx_error;
        return b;
    endfunction

    // One clock: sample at negedge, drive 1 time unit after posedge.
    task automatic step();
        rx_beat_t b;
        @(negedge clk0);
        b = cur_beat();
        if (hold_pending) begin
            check("hold_valid", 64'(bus.rx_valid), 64'd1);
            check("hold_beat", 64'(b), 64'(held));
        end
        hold_pending = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_ready) begin
                got_q.push_back(b);
                got_cyc_q.push_back(cyc);
            end else begin
                hold_pending = 1'b1;
                held = b;
            end
        end
        if (bus.fifo_valid && bus.fifo_ready) begin
            void'(fifo_q.pop_front());
            pops++;
            pop_cyc_q.push_back(cyc);
        end
        if (bus.drop) drops++;
        if (bus.cmd_valid && bus.cmd_ready) cmd_acc = 1'b1;
        @(posedge clk0);
        #1;
        cyc++;
        if (cmd_acc) bus.cmd_valid = 1'b0;
        bus.fifo_valid = (fifo_q.size() != 0) && (int'($urandom_range(0, 99)) >= gap_pct);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'($urandom);
        bus.rx_ready   = (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
    endtask

    task automatic build_expected(input int len_eff, input int off);
        n_exp = (off + len_eff + NB - 1) / NB;
        for (int b = 0; b < 16; b++) exp_a[b] = '0;
        for (int i = 0; i < len_eff; i++) begin
            int pos;
            pos = off + i;
            exp_a[pos / NB].data[(pos % NB) * 16 +: 16] = words_q[i];
            exp_a[pos / NB].strb[(pos % NB) * 2 +: 2]   = 2'b11;
        end
        exp_a[n_exp - 1].last = 1'b1;
    endtask

    task automatic issue_cmd(input int len, input int off, input string tag);
        got_q.delete();
        got_cyc_q.delete();
        pop_cyc_q.delete();
        cmd_acc        = 1'b0;
        bus.cmd_len    = 16'(len);
        bus.cmd_offset = 1'(off);
        bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 20 && !cmd_acc; i++) step();
        check({tag, "_cmd_accepted"}, 64'(cmd_acc), 64'd1);
    endtask

    task automatic wait_beats(input int n, input int bound, input string tag);
        for (int i = 0; i < bound && got_q.size() < n; i++) step();
        check({tag, "_beat_count"}, 64'(got_q.size()), 64'(n));
    endtask

    task automatic check_beats(input string tag);
        for (int b = 0; b < n_exp; b++) begin
            logic [63:0] obs;
            obs = (b < got_q.size()) ? 64'(got_q[b]) : 64'hDEAD_BEEF;
            check($sformatf("%s_beat%0d", tag, b), obs, 64'(exp_a[b]));
        end
    endtask

    task automatic run_burst(input int len, input int off, input string tag);
        int len_eff;
        len_eff = (len == 0) ? 1 : len;
        build_expected(len_eff, off);
        issue_cmd(len, off, tag);
        fifo_q = words_q;
        wait_beats(n_exp, 400, tag);
        check_beats(tag);
        for (int i = 0; i < 3; i++) step();
        check({tag, "_no_extra"}, 64'(got_q.size()), 64'(n_exp));
    endtask

    initial begin
        int d0;
        int diff;

        bus.cmd_valid  = 1'b0;
        bus.cmd_len    = '0;
        bus.cmd_offset = '0;
        bus.fifo_valid = 1'b0;
        bus.fifo_data  = '0;
        bus.rx_ready   = 1'b1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk0);
        #1;

        // Reset state.
        check("rst_cmd_ready",  64'(bus.cmd_ready),  64'd1);
        check("rst_fifo_ready", 64'(bus.fifo_ready), 64'd1);
        check("rst_rx_valid",   64'(bus.rx_valid),   64'd0);
        check("rst_rx_data",    64'(bus.rx_data),    64'd0);
        check("rst_rx_strb",    64'(bus.rx_strb),    64'd0);
        check("rst_rx_last",    64'(bus.rx_last),    64'd0);
        check("rst_rx_error",   64'(bus.rx_error),   64'd0);
        check("rst_drop",       64'(bus.drop),       64'd0);
        rst_i = 1'b0;
        step();

        // Back-to-back len=4 offset=0 with one-cycle pop-to-valid latency.
        ready_pct = 100; gap_pct = 0;
        words_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_burst(4, 0, "b2b");
        check("b2b_lat0", 64'(got_cyc_q[0] - pop_cyc_q[1]), 64'd1);
        check("b2b_lat1", 64'(got_cyc_q[1] - pop_cyc_q[3]), 64'd1);

        // Offset 1, odd length.
        words_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        run_burst(3, 1, "off1");

        // Output backpressure after the first beat.
        rand_words(4);
        build_expected(4, 0);
        ready_pct = 0;
        issue_cmd(4, 0, "bp");
        fifo_q = words_q;
        for (int i = 0; i < 20 && !bus.rx_valid; i++) step();
        check("bp_first_valid", 64'(bus.rx_valid), 64'd1);
        repeat (5) step();
        check("bp_fifo_ready_low", 64'(bus.fifo_ready), 64'd0);
        check("bp_still_valid",    64'(bus.rx_valid),   64'd1);
        ready_pct = 100;
        wait_beats(n_exp, 50, "bp");
        check_beats("bp");

        // Timeout with only one of four words delivered.
        words_q = '{16'h5A5A};
        build_expected(1, 0);
        exp_a[0].error = 1'b1;
        issue_cmd(4, 0, "to");
        fifo_q = words_q;
        wait_beats(1, 40, "to");
        check_beats("to");
        diff = got_cyc_q[0] - pop_cyc_q[0];
        check("to_delay_min", 64'(diff >= TO), 64'd1);
        check("to_delay_max", 64'(diff <= TO + 3), 64'd1);
        d0 = drops;
        fifo_q.push_back(16'hBEEF);
        repeat (4) step();
        check("to_late_drop", 64'(drops - d0), 64'd1);
        check("to_late_no_beat", 64'(got_q.size()), 64'd1);

        // Stray words while idle.
        got_q.delete();
        d0 = drops;
        fifo_q.push_back(16'h0101);
        fifo_q.push_back(16'h0202);
        repeat (6) step();
        check("stray_drops", 64'(drops - d0), 64'd2);
        check("stray_no_beat", 64'(got_q.size()), 64'd0);

        // Reset in the middle of a burst.
        words_q = '{16'h7777};
        issue_cmd(4, 0, "rst_mid");
        fifo_q = words_q;
        d0 = pops;
        for (int i = 0; i < 10 && pops == d0; i++) step();
        rst_i = 1'b1;
        #1;
        check("rstmid_cmd_ready",  64'(bus.cmd_ready),  64'd1);
        check("rstmid_fifo_ready", 64'(bus.fifo_ready), 64'd1);
        check("rstmid_rx_valid",   64'(bus.rx_valid),   64'd0);
        check("rstmid_rx_beat",    64'(cur_beat()),     64'd0);
        hold_pending = 1'b0;
        fifo_q.delete();
        repeat (2) @(posedge clk0);
        #1;
        rst_i = 1'b0;
        step();
        rand_words(2);
        run_burst(2, 0, "post_rst");

        // Randomised bursts with FIFO gaps and output stalls.
        gap_pct = 10;
        for (int k = 0; k < 24; k++) begin
            int len;
            int off;
            len = (k == 0) ? 0 : int'($urandom_range(1, 9));
            off = int'($urandom_range(0, 1));
            ready_pct = (k % 3 == 0) ? 100 : 85;
            rand_words((len == 0) ? 1 : len);
            run_burst(len, off, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
